// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, reset PC and state encoding for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int PC_W    = 18;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 18'h00000;

  // Fetch FSM: issue a request, wait out the controller latency, or park a
  // captured word that could not enter a stalled output slot.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_word_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Two-entry prefetch FIFO of {pc, instr} words with flush.
//               Only compiled when PREFETCH_BUF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef PREFETCH_BUF_EN
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        push_i,
  input  fetch_word_t data_i,
  input  logic        pop_i,
  output fetch_word_t data_o,
  output logic [1:0]  count_o
);

  fetch_word_t mem_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic        w_do_push;
  logic        w_do_pop;

  // Overflowing pushes and underflowing pops are ignored.
  assign w_do_push = push_i && (count_q != 2'd2);
  assign w_do_pop  = pop_i && (count_q != 2'd0);
  assign data_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage, pointers and occupancy; flush empties the FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (w_do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

endmodule : fetch_fifo
`endif
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Issues one word request at a time to
//               the memory controller, captures the reply after MC_LATENCY
//               cycles and hands {instr, pc, valid} to decode under a stall
//               handshake. Branch redirects squash any word in flight.
//               Optional feature macro: PREFETCH_BUF_EN (2-entry prefetch
//               FIFO replacing the single hold register).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              PC_STEP    = 2,
  parameter int              MC_LATENCY = 2
) (
  input  logic               clock,
  input  logic               reset,
  output logic               if_mc_en,
  output logic [PC_W-1:0]    if_mc_addr,
  input  logic [INSTR_W-1:0] mc_if_data,
  input  logic               mem_mc_en,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid,
  input  logic               id_if_stall,
  input  logic               ex_if_branch,
  input  logic [PC_W-1:0]    ex_if_target
);

  localparam int              CNT_W    = (MC_LATENCY > 1) ? $clog2(MC_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 1);
  localparam logic [PC_W-1:0]  PC_INC   = PC_W'(PC_STEP);

  fetch_state_t         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 squash_q, squash_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [PC_W-1:0]      opc_q, opc_d;
  logic                 valid_q, valid_d;

  logic                 w_consumed;
  logic                 w_slot_free;
  logic                 w_issue_ok;
  logic                 w_accept;
  fetch_word_t          w_word;

`ifdef PREFETCH_BUF_EN
  logic                 w_fifo_push;
  logic                 w_fifo_pop;
  logic                 w_fifo_flush;
  fetch_word_t          w_fifo_head;
  logic [1:0]           w_fifo_count;

  fetch_fifo u_fetch_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush_i (w_fifo_flush),
    .push_i  (w_fifo_push),
    .data_i  (w_word),
    .pop_i   (w_fifo_pop),
    .data_o  (w_fifo_head),
    .count_o (w_fifo_count)
  );

  // Prefetch ahead of decode until the FIFO could not absorb another word.
  assign w_issue_ok = (state_q == S_REQ) && (w_fifo_count < 2'd2);
`else
  fetch_word_t          hold_q, hold_d;

  // Only issue when the reply is guaranteed a place in the output slot.
  assign w_issue_ok = (state_q == S_REQ) && w_slot_free;
`endif

  assign w_consumed  = valid_q && !id_if_stall;
  assign w_slot_free = !valid_q || !id_if_stall;
  assign w_accept    = w_issue_ok && !mem_mc_en;
  assign w_word      = '{pc: pc_q, instr: mc_if_data};

  // Request is masked while reset is held so the port is idle in reset.
  assign if_mc_en    = reset && w_issue_ok;
  assign if_mc_addr  = if_mc_en ? pc_q : '0;
  assign if_id_instr = instr_q;
  assign if_id_pc    = opc_q;
  assign if_id_valid = valid_q;

  // State register and output slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_REQ;
      cnt_q    <= '0;
      squash_q <= 1'b0;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      opc_q    <= '0;
      valid_q  <= 1'b0;
`ifndef PREFETCH_BUF_EN
      hold_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      squash_q <= squash_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      opc_q    <= opc_d;
      valid_q  <= valid_d;
`ifndef PREFETCH_BUF_EN
      hold_q   <= hold_d;
`endif
    end
  end

  // Next-state: FSM progress, word routing, then branch override last.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    squash_d = squash_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    opc_d    = opc_q;
    valid_d  = valid_q;
`ifdef PREFETCH_BUF_EN
    w_fifo_push  = 1'b0;
    w_fifo_pop   = 1'b0;
    w_fifo_flush = 1'b0;
`else
    hold_d   = hold_q;
`endif

    if (w_consumed) valid_d = 1'b0;

`ifdef PREFETCH_BUF_EN
    // Oldest buffered word moves forward whenever the slot frees up.
    if (w_slot_free && (w_fifo_count != 2'd0)) begin
      instr_d    = w_fifo_head.instr;
      opc_d      = w_fifo_head.pc;
      valid_d    = 1'b1;
      w_fifo_pop = 1'b1;
    end
`endif

    unique case (state_q)
      S_REQ: begin
        if (w_accept) begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = S_REQ;
          squash_d = 1'b0;
          if (!squash_q) begin
            pc_d = pc_q + PC_INC;
`ifdef PREFETCH_BUF_EN
            if (w_slot_free && (w_fifo_count == 2'd0)) begin
              instr_d = w_word.instr;
              opc_d   = w_word.pc;
              valid_d = 1'b1;
            end else begin
              w_fifo_push = 1'b1;
            end
`else
            if (w_slot_free) begin
              instr_d = w_word.instr;
              opc_d   = w_word.pc;
              valid_d = 1'b1;
            end else begin
              hold_d  = w_word;
              state_d = S_HOLD;
            end
`endif
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
`ifdef PREFETCH_BUF_EN
        state_d = S_REQ;
`else
        if (w_slot_free) begin
          instr_d = hold_q.instr;
          opc_d   = hold_q.pc;
          valid_d = 1'b1;
          hold_d  = '0;
          state_d = S_REQ;
        end
`endif
      end
      default: state_d = S_REQ;
    endcase

    // A redirect wins over everything else on this edge. A reply still owed
    // by the controller is waited out and dropped through squash.
    if (ex_if_branch) begin
      pc_d    = ex_if_target;
      instr_d = instr_q;
      opc_d   = opc_q;
      valid_d = 1'b0;
`ifdef PREFETCH_BUF_EN
      w_fifo_push  = 1'b0;
      w_fifo_pop   = 1'b0;
      w_fifo_flush = 1'b1;
`else
      hold_d  = '0;
`endif
      if ((state_q == S_WAIT) && (cnt_q != '0)) begin
        state_d  = S_WAIT;
        squash_d = 1'b1;
      end else begin
        state_d  = S_REQ;
        cnt_d    = cnt_q;
        squash_d = 1'b0;
      end
    end
  end

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a simple
//               fixed-latency memory controller responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        if_mc_en;
  logic [17:0] if_mc_addr;
  logic [31:0] mc_if_data;
  logic        mem_mc_en;
  logic [31:0] if_id_instr;
  logic [17:0] if_id_pc;
  logic        if_id_valid;
  logic        id_if_stall;
  logic        ex_if_branch;
  logic [17:0] ex_if_target;

  int n_assert = 0;
  int n_fail   = 0;

  logic [17:0] lat_addr = '0;

  fetch_unit dut (
    .clock        (clock),
    .reset        (reset),
    .if_mc_en     (if_mc_en),
    .if_mc_addr   (if_mc_addr),
    .mc_if_data   (mc_if_data),
    .mem_mc_en    (mem_mc_en),
    .if_id_instr  (if_id_instr),
    .if_id_pc     (if_id_pc),
    .if_id_valid  (if_id_valid),
    .id_if_stall  (id_if_stall),
    .ex_if_branch (ex_if_branch),
    .ex_if_target (ex_if_target)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM contents seen by the fetch port.
  function automatic logic [31:0] mem_word(input logic [17:0] a);
    if (a == 18'h0)      return 32'h11112222;
    else if (a == 18'h2) return 32'h33334444;
    else                 return {14'h0, a} | 32'hAB000000;
  endfunction

  // Controller model: latch the address on an accepted request, hold data.
  always @(posedge clock) begin
    if (reset && if_mc_en && !mem_mc_en) lat_addr <= if_mc_addr;
  end
  assign mc_if_data = mem_word(lat_addr);

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] ins,
                           input logic [17:0] pc);
    check({tag, "_valid"}, {31'h0, if_id_valid}, {31'h0, v});
    check({tag, "_instr"}, if_id_instr, ins);
    check({tag, "_pc"},    {14'h0, if_id_pc}, {14'h0, pc});
  endtask

  task automatic check_req(input string tag, input logic en, input logic [17:0] addr);
    check({tag, "_en"},   {31'h0, if_mc_en}, {31'h0, en});
    check({tag, "_addr"}, {14'h0, if_mc_addr}, {14'h0, addr});
  endtask

  initial begin
    reset        = 1'b0;
    mem_mc_en    = 1'b0;
    id_if_stall  = 1'b0;
    ex_if_branch = 1'b0;
    ex_if_target = '0;

    // Reset state.
    tick(2);
    check_req("rst", 1'b0, 18'h0);
    check_out("rst", 1'b0, 32'h0, 18'h0);

    // Release: first request to RESET_PC straight away.
    reset = 1'b1;
    #1;
    check_req("first", 1'b1, 18'h0);
    tick(2);
    check("e2_valid", {31'h0, if_id_valid}, 32'h0);
    tick(1);
    check_out("word0", 1'b1, 32'h11112222, 18'h0);
    check_req("word0", 1'b1, 18'h2);
    tick(1);
    check("e4_valid", {31'h0, if_id_valid}, 32'h0);
    check("e4_en", {31'h0, if_mc_en}, 32'h0);
    tick(2);
    check_out("word2", 1'b1, 32'h33334444, 18'h2);
    check_req("word2", 1'b1, 18'h4);

    // Memory stage owns the RAM for 5 cycles: request retried, same address.
    mem_mc_en = 1'b1;
    tick(1);
    check("blk1_valid", {31'h0, if_id_valid}, 32'h0);
    check_req("blk1", 1'b1, 18'h4);
    tick(4);
    check_req("blk5", 1'b1, 18'h4);
    mem_mc_en = 1'b0;
    tick(1);
    check("blk_acc_en", {31'h0, if_mc_en}, 32'h0);
    tick(2);
    check_out("word4", 1'b1, 32'hAB000004, 18'h4);
    check_req("word4", 1'b1, 18'h6);

    // Decode stall for 4 cycles with word 6 in flight.
    tick(1);
    check_out("acc6", 1'b0, 32'hAB000004, 18'h4);
    id_if_stall = 1'b1;
    tick(2);
    check_out("stall_a", 1'b1, 32'hAB000006, 18'h6);
    check("stall_a_en", {31'h0, if_mc_en}, 32'h0);
    tick(2);
    check_out("stall_b", 1'b1, 32'hAB000006, 18'h6);
    check("stall_b_en", {31'h0, if_mc_en}, 32'h0);
    id_if_stall = 1'b0;
    #1;
    check_req("unstall", 1'b1, 18'h8);
    tick(1);
    check("unstall_valid", {31'h0, if_id_valid}, 32'h0);
    tick(2);
    check_out("word8", 1'b1, 32'hAB000008, 18'h8);
    check_req("word8", 1'b1, 18'hA);

    // Branch to 0x100 while word 0xA is in flight.
    tick(1);
    check("acc10_en", {31'h0, if_mc_en}, 32'h0);
    ex_if_branch = 1'b1;
    ex_if_target = 18'h100;
    tick(1);
    ex_if_branch = 1'b0;
    check("br_wait_en", {31'h0, if_mc_en}, 32'h0);
    check("br_wait_valid", {31'h0, if_id_valid}, 32'h0);
    tick(1);
    check("squash_valid", {31'h0, if_id_valid}, 32'h0);
    check_req("br_target", 1'b1, 18'h100);
    tick(3);
    check_out("word100", 1'b1, 32'hAB000100, 18'h100);

    // Branch in S_REQ to the top of the address space, then wrap.
    ex_if_branch = 1'b1;
    ex_if_target = 18'h3FFFE;
    tick(1);
    ex_if_branch = 1'b0;
    check_req("br_top", 1'b1, 18'h3FFFE);
    check("br_top_valid", {31'h0, if_id_valid}, 32'h0);
    tick(3);
    check_out("wordtop", 1'b1, 32'hAB03FFFE, 18'h3FFFE);
    check_req("wrap", 1'b1, 18'h0);

    // Reset while waiting on the controller.
    tick(1);
    reset = 1'b0;
    #1;
    check_req("midrst", 1'b0, 18'h0);
    check_out("midrst", 1'b0, 32'h0, 18'h0);
    tick(1);
    reset = 1'b1;
    #1;
    check_req("restart", 1'b1, 18'h0);
    tick(2);
    check("restart_e2_valid", {31'h0, if_id_valid}, 32'h0);
    tick(1);
    check_out("restart_word0", 1'b1, 32'h11112222, 18'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
